// File: rtl/req_encoder16x4_if.sv
// req_encoder16x4_if: request/handshake bundle between event sources, encoder and consumer
interface req_encoder16x4_if;
   logic        enable;
   logic [15:0] req;
   logic        out_ready;
   logic        out_valid;
   logic [3:0]  out_code;
   logic [15:0] ack;
   logic [15:0] pending;
   modport master (output enable, req, out_ready, input out_valid, out_code, ack, pending);
   modport slave (input enable, req, out_ready, output out_valid, out_code, ack, pending);
endinterface

// File: rtl/req_encoder16x4.sv
// req_encoder16x4: sticky 16-request collector presenting the highest pending index over valid/ready
module req_encoder16x4 (
   input logic clk,
   input logic rst_n,
   req_encoder16x4_if.slave bus
);
   logic [15:0] cand, pend_n, ack_n;
   logic [3:0]  idx;
   logic        free, load;
   always_comb begin
      cand = bus.pending | bus.req;
      idx = '0;
      for (int i = 0; i < 16; i++) idx = cand[i] ? 4'(i) : idx;
      free = !bus.out_valid || bus.out_ready;
      load = free && bus.enable && (cand != '0);
      // the loaded bit is consumed even if its req is high this cycle
      pend_n = load ? cand & ~(16'h1 << idx) : cand;
      ack_n = (bus.out_valid && bus.out_ready) ? 16'h1 << bus.out_code : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pending <= '0;
         bus.out_valid <= 1'b0;
         bus.out_code <= '0;
         bus.ack <= '0;
      end else begin
         bus.pending <= pend_n;
         bus.out_valid <= free ? load : bus.out_valid;
         bus.out_code <= load ? idx : bus.out_code;
         bus.ack <= ack_n;
      end
   end
endmodule

// File: tb/tb_req_encoder16x4.sv
// tb_req_encoder16x4: directed scenarios plus randomized traffic against a queue-free service model
module tb_req_encoder16x4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   req_encoder16x4_if bus ();
   req_encoder16x4 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] m_pend = '0;
   logic [15:0] m_ack = '0;
   logic        m_valid = 1'b0;
   logic [3:0]  m_code = '0;

   // model: a set of waiting indices; service takes the largest one when the slot is free
   task automatic cycle();
      logic [15:0] waiting;
      int top;
      if (rst_n) begin
         waiting = m_pend | bus.req;
         m_ack = (m_valid && bus.out_ready) ? 16'(1 << m_code) : 16'h0;
         if (!m_valid || bus.out_ready) begin
            top = -1;
            for (int k = 15; k >= 0; k--) if (top < 0 && waiting[k]) top = k;
            if (bus.enable && top >= 0) begin
               m_valid = 1'b1;
               m_code = 4'(top);
               waiting[top] = 1'b0;
            end else m_valid = 1'b0;
         end
         m_pend = waiting;
      end else begin
         m_pend = '0; m_ack = '0; m_valid = 1'b0; m_code = '0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = 16'hFFFF; bus.enable = 1'b1; bus.out_ready = 1'b1;
      cycle(); cycle();
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_code !== 4'd0) begin n_err++; $display("FAIL reset_code got %0d want 0", bus.out_code); end
      n_cmp++; if (bus.ack !== 16'h0) begin n_err++; $display("FAIL reset_ack got %h want 0000", bus.ack); end
      n_cmp++; if (bus.pending !== 16'h0) begin n_err++; $display("FAIL reset_pending got %h want 0000", bus.pending); end
      bus.req = '0;
      rst_n = 1'b1;
      cycle();
   endtask

   task automatic test_single_pulse();
      bus.req = 16'h0020; cycle(); bus.req = '0;
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_code !== 4'd5) begin n_err++; $display("FAIL single_load got v=%b c=%0d want v=1 c=5", bus.out_valid, bus.out_code); end
      cycle();
      n_cmp++; if (bus.ack !== 16'h0020 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_ack got ack=%h v=%b want ack=0020 v=0", bus.ack, bus.out_valid); end
      cycle();
      n_cmp++; if (bus.ack !== 16'h0) begin n_err++; $display("FAIL single_ack_once got %h want 0000", bus.ack); end
   endtask

   task automatic test_priority();
      logic [3:0] codes [3] = '{4'd15, 4'd3, 4'd0};
      logic [15:0] acks [3] = '{16'h8000, 16'h0008, 16'h0001};
      bus.req = 16'h8009; cycle(); bus.req = '0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_code !== codes[i]) begin n_err++; $display("FAIL prio_code%0d got v=%b c=%0d want v=1 c=%0d", i, bus.out_valid, bus.out_code, codes[i]); end
         cycle();
         n_cmp++; if (bus.ack !== acks[i]) begin n_err++; $display("FAIL prio_ack%0d got %h want %h", i, bus.ack, acks[i]); end
      end
      n_cmp++; if (bus.pending !== 16'h0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL prio_drain got p=%h v=%b want p=0000 v=0", bus.pending, bus.out_valid); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.req = 16'h0008; cycle();
      bus.req = 16'h4000;
      for (int i = 0; i < 4; i++) begin
         cycle(); bus.req = '0;
         n_cmp++; if (bus.out_code !== 4'd3 || bus.out_valid !== 1'b1 || bus.ack !== 16'h0) begin n_err++; $display("FAIL bp_hold%0d got v=%b c=%0d a=%h want v=1 c=3 a=0000", i, bus.out_valid, bus.out_code, bus.ack); end
      end
      n_cmp++; if (bus.pending !== 16'h4000) begin n_err++; $display("FAIL bp_pending got %h want 4000", bus.pending); end
      bus.out_ready = 1'b1; cycle();
      n_cmp++; if (bus.out_code !== 4'd14 || bus.ack !== 16'h0008) begin n_err++; $display("FAIL bp_next got c=%0d a=%h want c=14 a=0008", bus.out_code, bus.ack); end
      cycle(); cycle();
   endtask

   task automatic test_rerequest();
      int n_ack7 = 0;
      bus.out_ready = 1'b0;
      bus.req = 16'h0080; cycle();
      cycle(); bus.req = '0;
      n_cmp++; if (bus.pending[7] !== 1'b1 || bus.out_code !== 4'd7) begin n_err++; $display("FAIL rereq_pend got p=%h c=%0d want p[7]=1 c=7", bus.pending, bus.out_code); end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (bus.ack == 16'h0080) n_ack7++;
      end
      n_cmp++; if (n_ack7 != 2) begin n_err++; $display("FAIL rereq_acks got %0d want 2", n_ack7); end
   endtask

   task automatic test_enable();
      bus.enable = 1'b0;
      bus.req = 16'h0204; cycle(); bus.req = '0; cycle();
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.pending !== 16'h0204) begin n_err++; $display("FAIL en_gate got v=%b p=%h want v=0 p=0204", bus.out_valid, bus.pending); end
      bus.enable = 1'b1; cycle();
      n_cmp++; if (bus.out_code !== 4'd9 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL en_first got v=%b c=%0d want v=1 c=9", bus.out_valid, bus.out_code); end
      cycle();
      n_cmp++; if (bus.out_code !== 4'd2 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL en_second got v=%b c=%0d want v=1 c=2", bus.out_valid, bus.out_code); end
      cycle(); cycle();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      bus.req = 16'h0108; cycle(); bus.req = '0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_code !== 4'd0 || bus.ack !== 16'h0 || bus.pending !== 16'h0) begin n_err++; $display("FAIL mid_reset got v=%b c=%0d a=%h p=%h want all 0", bus.out_valid, bus.out_code, bus.ack, bus.pending); end
      cycle();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.req = 16'($urandom & $urandom & $urandom);
         bus.out_ready = $urandom_range(0, 3) != 0;
         bus.enable = $urandom_range(0, 7) != 0;
         cycle();
         n_cmp++;
         if ({bus.out_valid, bus.out_code, bus.ack, bus.pending} !== {m_valid, m_code, m_ack, m_pend}) begin
            n_err++;
            $display("FAIL rand%0d got v=%b c=%0d a=%h p=%h want v=%b c=%0d a=%h p=%h", i, bus.out_valid, bus.out_code, bus.ack, bus.pending, m_valid, m_code, m_ack, m_pend);
         end
         n_cmp++; if (!$onehot0(bus.ack)) begin n_err++; $display("FAIL rand_ack_onehot%0d got %h want at most one bit", i, bus.ack); end
      end
      bus.req = '0; bus.enable = 1'b1; bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) cycle();
      n_cmp++; if (bus.pending !== 16'h0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rand_drain got p=%h v=%b want p=0000 v=0", bus.pending, bus.out_valid); end
   endtask

   initial begin
      bus.req = '0; bus.enable = 1'b1; bus.out_ready = 1'b1;
      #1;
      test_reset();
      test_single_pulse();
      test_priority();
      test_backpressure();
      test_rerequest();
      test_enable();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
